uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_pin_i  input  1  serial line, asynchronous to clk, idle high.
- baud_div_i  input  UART_BAUD_DIV_SIZE  clk cycles per bit.
- two_stop_bits  input  1  1 = two stop bits expected.
- rx_data_o  output  UART_DATA_SIZE  received byte.
- valid_o  output  1  rx_data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts the byte.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: byte dropped because valid_o was still high.

Function
REQ-003 rx_pin_i SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-004 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1), or 2 if two_stop_bits=1.
REQ-005 two_stop_bits and baud_div_i SHALL be captured on start-bit detection and held for the whole frame.
REQ-006 baud_div_i < 4 SHALL be unsupported; behaviour is undefined.
REQ-007 The state machine SHALL be IDLE -> START -> DATA -> STOP -> IDLE.
REQ-008 IDLE: a synchronized falling edge (1 -> 0) SHALL move to START and load the sample counter with baud_div>>1. A constant-low line SHALL NOT retrigger.
REQ-009 The sample counter SHALL decrement each cycle. sample_pulse SHALL occur when the counter equals 1; on each pulse the counter SHALL reload with the captured baud_div.
REQ-010 START, on sample_pulse: line 0 -> DATA; line 1 -> IDLE (false start; nothing reported).
REQ-011 DATA: each sample_pulse SHALL shift one bit in at the MSB of the shifter; after 8 pulses -> STOP.
REQ-012 STOP, on each stop-bit sample_pulse: a line value of 0 SHALL pulse frame_err_o, discard the byte, and go to IDLE.
REQ-013 STOP: after the last good stop bit, the byte SHALL be delivered and the state SHALL go to IDLE.
REQ-014 Delivery SHALL occur in the cycle after the final stop sample_pulse: rx_data_o <= shifter, valid_o <= 1.
REQ-015 valid_o SHALL stay high and rx_data_o SHALL stay stable until a cycle with valid_o && ready_i; valid_o SHALL clear in the following cycle.
REQ-016 Delivery while valid_o=1 and ready_i=0: the new byte SHALL be dropped, rx_data_o SHALL be unchanged, and overrun_o SHALL pulse.
REQ-017 Delivery in the same cycle as valid_o && ready_i: the new byte SHALL load, valid_o SHALL remain 1, and there SHALL be no overrun.
REQ-018 Latency: valid_o SHALL rise 2 (sync) + 1 cycles after the line sample that completes the last stop bit.

Reset
REQ-019 rst_n low SHALL immediately force:
- state IDLE;
- valid_o, frame_err_o, overrun_o, rx_data_o, shifter and counters to 0;
- synchronizer flops to 1.
REQ-020 Reset mid-frame SHALL abandon the frame. After reset release, a frame SHALL be detected only on a new falling edge, with no false start from the idle-high line.

Configuration
REQ-021 Macro UART_RX_FRAME_ERR_EN SHALL control stop-bit checking.
- Defined: stop bits are checked per REQ-012.
- Undefined: stop-bit values are ignored, every frame is delivered, and frame_err_o is tied 0.

Structure
REQ-022 The shared UART definitions SHALL hold UART_DATA_SIZE, UART_BAUD_DIV_SIZE, the data-bit count and state enum type_uart_rx_states_e.
REQ-023 The synchronizer and falling-edge detector SHALL be sub-module uart_rx_sync; all other logic SHALL be in uart_rx.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- baud_div_i=16, two_stop_bits=0, frame for 0xA5, ready_i=1: rx_data_o=0xA5, valid_o high exactly 1 cycle, no error pulses.
- baud_div_i=16, two_stop_bits=1, byte 0x3C, ready_i=0: valid_o held high with 0x3C. Second byte 0x55 before ready_i: overrun_o pulses once, rx_data_o stays 0x3C. ready_i=1: valid_o clears.
- Line low for 4 cycles then high (baud_div_i=16): no DATA entry, no valid_o, no errors.
- Byte 0x0F with stop bit driven 0: with UART_RX_FRAME_ERR_EN, frame_err_o pulses and valid_o stays 0; without it, valid_o rises with 0x0F.
- rst_n asserted in the middle of data bit 4: outputs 0 immediately. The next clean frame 0x81 after release is received correctly.
- Byte completes in the same cycle as valid_o && ready_i on the previous byte: new byte presented, valid_o stays 1, no overrun_o.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: data/divider widths, bit count, FSM state type.
package uart_rx_pkg;

  localparam int UART_DATA_SIZE     = 8;
  localparam int UART_BAUD_DIV_SIZE = 16;
  localparam int UART_DATA_BITS     = 8;
  localparam int UART_BIT_CNT_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } type_uart_rx_states_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector
// that looks only at synchronized samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync_o = sync_q;
  assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 / 8N2 framing, mid-bit sampling from a programmable divider,
// valid/ready output holding register with overrun detection.
// Optional macro UART_RX_FRAME_ERR_EN enables stop-bit checking and frame_err_o;
// without it stop-bit values are ignored and every frame is delivered.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a synchronized 1->0 edge on the line
// ST_START | half a bit time in; confirm start bit is still low
// ST_DATA  | sampling 8 data bits, LSB first, into the shifter MSB
// ST_STOP  | sampling one or two stop bits, then deliver or flag error
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_pin_i,
  input  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i,
  input  logic                          two_stop_bits,
  output logic [UART_DATA_SIZE-1:0]     rx_data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam logic [UART_BAUD_DIV_SIZE-1:0] CNT_ONE  = UART_BAUD_DIV_SIZE'(1);
  localparam logic [UART_BIT_CNT_W-1:0]     LAST_BIT = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

  type_uart_rx_states_e state_q, state_d;

  logic [UART_BAUD_DIV_SIZE-1:0] cnt_q, cnt_d;
  logic [UART_BAUD_DIV_SIZE-1:0] div_q, div_d;
  logic                          two_stop_q, two_stop_d;
  logic [UART_BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                          stop_cnt_q, stop_cnt_d;
  logic [UART_DATA_SIZE-1:0]     shifter_q, shifter_d;
  logic [UART_DATA_SIZE-1:0]     data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          ferr_q, ferr_d;
  logic                          ovr_q, ovr_d;

  logic rx_sync;
  logic rx_fall;
  logic sample_pulse;
  logic deliver;
  logic stop_bad;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin_i  (rx_pin_i),
    .rx_sync_o (rx_sync),
    .fall_o    (rx_fall)
  );

  assign sample_pulse = (state_q != ST_IDLE) && (cnt_q == CNT_ONE);

`ifdef UART_RX_FRAME_ERR_EN
  assign stop_bad = ~rx_sync;
`else
  assign stop_bad = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shifter_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      two_stop_q <= two_stop_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shifter_q  <= shifter_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Frame FSM: bit timing, sampling, and end-of-frame decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    two_stop_d = two_stop_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shifter_d  = shifter_q;
    ferr_d     = 1'b0;
    deliver    = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = sample_pulse ? div_q : (cnt_q - CNT_ONE);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d    = ST_START;
          div_d      = baud_div_i;
          two_stop_d = two_stop_bits;
          cnt_d      = baud_div_i >> 1;
        end
      end
      ST_START: begin
        if (sample_pulse) begin
          state_d   = rx_sync ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_pulse) begin
          shifter_d = {rx_sync, shifter_q[UART_DATA_SIZE-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      ST_STOP: begin
        if (sample_pulse) begin
          if (stop_bad) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output holding register: consume on valid&&ready, drop new byte on overrun.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (valid_q && !ready_i) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shifter_q;
        valid_d = 1'b1;
      end
    end
  end

  assign rx_data_o   = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a queue-based reference of what the line carried.
module tb_uart_rx;

`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FERR_EN = 1'b1;
`else
  localparam bit FERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_pin;
  logic [15:0] baud_div;
  logic        two_stop;
  logic [7:0]  rx_data;
  logic        valid;
  logic        ready;
  logic        frame_err;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  // Observed-behaviour bookkeeping, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         valid_cycles = 0;
  int         ovr_cnt      = 0;
  int         ferr_cnt     = 0;
  int         b2b_cnt      = 0;
  logic [7:0] b2b_data     = '0;
  logic       prev_hs      = 1'b0;

  uart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin_i      (rx_pin),
    .baud_div_i    (baud_div),
    .two_stop_bits (two_stop),
    .rx_data_o     (rx_data),
    .valid_o       (valid),
    .ready_i       (ready),
    .frame_err_o   (frame_err),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (overrun) ovr_cnt++;
    if (frame_err) ferr_cnt++;
    if (prev_hs && valid) begin
      b2b_cnt++;
      b2b_data = rx_data;
    end
    if (valid && ready) got_q.push_back(rx_data);
    prev_hs = valid && ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    valid_cycles = 0;
    ovr_cnt      = 0;
    ferr_cnt     = 0;
    b2b_cnt      = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hxxxxxxxx;
  endfunction

  // Drive one frame on the line: start, 8 data bits LSB first, stop bit(s), idle.
  task automatic send_frame(input logic [7:0] b, input int div, input bit two, input bit stop_val);
    baud_div = 16'(div);
    two_stop = two;
    rx_pin = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(div);
    end
    rx_pin = stop_val;
    tick(div);
    if (two) begin
      rx_pin = 1'b1;
      tick(div);
    end
    rx_pin = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] b;
    int         div;
    bit         two;
    bit         ok;
    int         b2b_total;

    rst_n    = 1'b0;
    rx_pin   = 1'b1;
    ready    = 1'b0;
    baud_div = 16'd16;
    two_stop = 1'b0;
    #1;
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_data", {24'h0, rx_data}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_ovr", {31'h0, overrun}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Single byte, ready held high: one-cycle valid.
    clr();
    ready = 1'b1;
    send_frame(8'hA5, 16, 1'b0, 1'b1);
    tick(10);
    check("a5_count", got_q.size(), 1);
    check("a5_data", got_at(0), 32'hA5);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_ovr", ovr_cnt, 0);
    check("a5_ferr", ferr_cnt, 0);

    // Two stop bits, consumer stalled, then overrun on the second byte.
    clr();
    ready = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b1);
    tick(10);
    check("hold_valid", {31'h0, valid}, 32'h1);
    check("hold_data", {24'h0, rx_data}, 32'h3C);
    send_frame(8'h55, 16, 1'b1, 1'b1);
    tick(10);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_data_kept", {24'h0, rx_data}, 32'h3C);
    check("ovr_valid_kept", {31'h0, valid}, 32'h1);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    check("drain_valid", {31'h0, valid}, 32'h0);
    check("drain_count", got_q.size(), 1);
    check("drain_data", got_at(0), 32'h3C);

    // Short low glitch: false start, nothing reported.
    clr();
    ready = 1'b1;
    baud_div = 16'd16;
    rx_pin = 1'b0;
    tick(4);
    rx_pin = 1'b1;
    tick(200);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);

    // Bad stop bit.
    clr();
    send_frame(8'h0F, 16, 1'b0, 1'b0);
    tick(10);
    check("badstop_ferr", ferr_cnt, FERR_EN ? 1 : 0);
    check("badstop_count", got_q.size(), FERR_EN ? 0 : 1);
    check("badstop_data", got_at(0), FERR_EN ? 32'hxxxxxxxx : 32'h0F);

    // Reset in the middle of data bit 4 while a byte is pending.
    clr();
    ready = 1'b0;
    send_frame(8'h96, 16, 1'b0, 1'b1);
    tick(5);
    check("pre_rst_data", {24'h0, rx_data}, 32'h96);
    b = 8'hC3;
    rx_pin = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx_pin = b[i];
      tick(16);
    end
    rx_pin = b[4];
    tick(8);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, valid}, 32'h0);
    check("rst_mid_data", {24'h0, rx_data}, 32'h0);
    check("rst_mid_flags", {30'h0, frame_err, overrun}, 32'h0);
    rx_pin = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(20);
    clr();
    ready = 1'b1;
    send_frame(8'h81, 16, 1'b0, 1'b1);
    tick(10);
    check("post_rst_count", got_q.size(), 1);
    check("post_rst_data", got_at(0), 32'h81);
    check("post_rst_flags", ovr_cnt + ferr_cnt, 0);

    // Sweep a one-cycle ready pulse across the delivery of a second byte.
    // Every offset must either keep both bytes or drop the second with one
    // overrun; at the coincident offset the new byte loads with valid held.
    b2b_total = 0;
    for (int m = 150; m <= 158; m++) begin
      clr();
      x = 8'($urandom_range(0, 255));
      y = x ^ 8'h5A;
      ready = 1'b0;
      send_frame(x, 16, 1'b0, 1'b1);
      tick(5);
      fork
        send_frame(y, 16, 1'b0, 1'b1);
        begin
          tick(m);
          ready = 1'b1;
          tick(1);
          ready = 1'b0;
        end
      join
      tick(10);
      if (b2b_cnt > 0) begin
        b2b_total++;
        check("b2b_new_data", {24'h0, b2b_data}, {24'h0, y});
        check("b2b_no_ovr", ovr_cnt, 0);
      end
      ready = 1'b1;
      tick(3);
      ready = 1'b0;
      ok = (ovr_cnt == 1 && got_q.size() == 1 && got_q[0] == x) ||
           (ovr_cnt == 0 && got_q.size() == 2 && got_q[0] == x && got_q[1] == y);
      check("sweep_outcome", {31'h0, ok}, 32'h1);
    end
    check("b2b_seen", {31'h0, (b2b_total > 0)}, 32'h1);

    // Randomized good frames with random divider and stop-bit count.
    clr();
    ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom_range(0, 255));
      div = $urandom_range(6, 24);
      two = 1'($urandom_range(0, 1));
      exp_q.push_back(b);
      send_frame(b, div, two, 1'b1);
      tick($urandom_range(0, 7));
    end
    tick(10);
    check("rand_count", got_q.size(), exp_q.size());
    for (int n = 0; n < exp_q.size(); n++) begin
      check("rand_data", got_at(n), {24'h0, exp_q[n]});
    end
    check("rand_flags", ovr_cnt + ferr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
